wt_mem_arbiter: RTL and testbench

- Sits between the write-through I$/D$ memory request ports and the single memory adapter (AXI or L1.5).
- Arbitrates the two req/ack request streams onto one adapter request port, using round-robin with an owner lock.
- Tracks outstanding transactions per requester against a limit.
- Routes the adapter's return stream back to I$ or D$ by transaction ID.

---
 rtl/wt_mem_arbiter.sv | 109 ++++++++++
 tb/tb_wt_mem_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/wt_mem_arbiter.sv
// Arbiter between the write-through I$/D$ memory request ports and the single memory adapter.
// Round-robin with owner lock on requests, per-requester outstanding limits, TID-based return routing.
module wt_mem_arbiter #(
    parameter int unsigned ReqWidth       = 128,
    parameter int unsigned RtrnWidth      = 192,
    parameter int unsigned TidWidth       = 2,
    parameter int unsigned IcacheTid      = 0,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ic_req_i,
    output logic                 ic_ack_o,
    input  logic [ReqWidth-1:0]  ic_data_i,
    input  logic                 dc_req_i,
    output logic                 dc_ack_o,
    input  logic [ReqWidth-1:0]  dc_data_i,
    output logic                 mem_req_o,
    input  logic                 mem_ack_i,
    output logic [ReqWidth-1:0]  mem_data_o,
    input  logic                 mem_rtrn_vld_i,
    input  logic [TidWidth-1:0]  mem_rtrn_tid_i,
    input  logic [RtrnWidth-1:0] mem_rtrn_i,
    output logic                 ic_rtrn_vld_o,
    output logic                 dc_rtrn_vld_o,
    output logic [RtrnWidth-1:0] rtrn_o,
    output logic                 ic_busy_o,
    output logic                 dc_busy_o,
    output logic                 err_o
);

    typedef enum logic [1:0] {IDLE, LOCK_IC, LOCK_DC} state_e;

    state_e     state;
    logic       rr_dc;
    logic [3:0] cnt_ic, cnt_dc;
    logic       err_q;
    logic       ic_elig, dc_elig, owner_ic, owner_dc, req_v, rtrn_is_ic;

    always_comb begin
        ic_elig  = ic_req_i && (cnt_ic < 4'(MaxOutstanding));
        dc_elig  = dc_req_i && (cnt_dc < 4'(MaxOutstanding));
        owner_ic = 1'b0;
        owner_dc = 1'b0;
        case (state)
            IDLE: begin
                if (ic_elig && (!dc_elig || !rr_dc)) owner_ic = 1'b1;
                else if (dc_elig)                   owner_dc = 1'b1;
            end
            LOCK_IC: owner_ic = 1'b1;
            LOCK_DC: owner_dc = 1'b1;
            default: ;
        endcase
        // Outputs are forced quiet while reset is asserted, regardless of stale state.
        req_v      = !rst_i && (owner_ic || owner_dc);
        rtrn_is_ic = (mem_rtrn_tid_i == TidWidth'(IcacheTid));
    end

    assign mem_req_o     = req_v;
    assign mem_data_o    = owner_dc ? dc_data_i : ic_data_i;
    assign ic_ack_o      = mem_ack_i && req_v && owner_ic;
    assign dc_ack_o      = mem_ack_i && req_v && owner_dc;
    assign ic_rtrn_vld_o = !rst_i && mem_rtrn_vld_i && rtrn_is_ic;
    assign dc_rtrn_vld_o = !rst_i && mem_rtrn_vld_i && !rtrn_is_ic;
    assign rtrn_o        = mem_rtrn_i;
    assign ic_busy_o     = !rst_i && (cnt_ic != 4'd0);
    assign dc_busy_o     = !rst_i && (cnt_dc != 4'd0);
    assign err_o         = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            rr_dc  <= 1'b0;
            cnt_ic <= '0;
            cnt_dc <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (owner_ic) begin
                        if (mem_ack_i) rr_dc <= 1'b1;
                        else           state <= LOCK_IC;
                    end else if (owner_dc) begin
                        if (mem_ack_i) rr_dc <= 1'b0;
                        else           state <= LOCK_DC;
                    end
                end
                LOCK_IC: if (mem_ack_i) begin
                    state <= IDLE;
                    rr_dc <= 1'b1;
                end
                LOCK_DC: if (mem_ack_i) begin
                    state <= IDLE;
                    rr_dc <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            if ((state == LOCK_IC && !ic_req_i) || (state == LOCK_DC && !dc_req_i) ||
                (ic_rtrn_vld_o && cnt_ic == 4'd0) || (dc_rtrn_vld_o && cnt_dc == 4'd0))
                err_q <= 1'b1;

            // A return against an empty counter is an error and must not wrap below zero.
            cnt_ic <= cnt_ic + {3'b0, ic_ack_o} - {3'b0, ic_rtrn_vld_o && (cnt_ic != 4'd0)};
            cnt_dc <= cnt_dc + {3'b0, dc_ack_o} - {3'b0, dc_rtrn_vld_o && (cnt_dc != 4'd0)};
        end
    end

endmodule

// File: tb/tb_wt_mem_arbiter.sv
// Directed, table-driven bench for wt_mem_arbiter; each row is applied for one cycle and
// the combinational/registered outputs are compared on the falling edge.
module tb_wt_mem_arbiter;

    localparam int unsigned RW = 128;
    localparam int unsigned TW = 192;

    logic          clk_i = 1'b0;
    logic          rst_i, ic_req_i, dc_req_i, mem_ack_i, mem_rtrn_vld_i;
    logic [1:0]    mem_rtrn_tid_i;
    logic [RW-1:0] ic_data_i, dc_data_i, mem_data_o;
    logic [TW-1:0] mem_rtrn_i, rtrn_o;
    logic          ic_ack_o, dc_ack_o, mem_req_o, ic_rtrn_vld_o, dc_rtrn_vld_o;
    logic          ic_busy_o, dc_busy_o, err_o;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk_i = ~clk_i;

    wt_mem_arbiter #(
        .ReqWidth(RW), .RtrnWidth(TW), .TidWidth(2), .IcacheTid(0), .MaxOutstanding(4)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ic_req_i(ic_req_i), .ic_ack_o(ic_ack_o), .ic_data_i(ic_data_i),
        .dc_req_i(dc_req_i), .dc_ack_o(dc_ack_o), .dc_data_i(dc_data_i),
        .mem_req_o(mem_req_o), .mem_ack_i(mem_ack_i), .mem_data_o(mem_data_o),
        .mem_rtrn_vld_i(mem_rtrn_vld_i), .mem_rtrn_tid_i(mem_rtrn_tid_i), .mem_rtrn_i(mem_rtrn_i),
        .ic_rtrn_vld_o(ic_rtrn_vld_o), .dc_rtrn_vld_o(dc_rtrn_vld_o), .rtrn_o(rtrn_o),
        .ic_busy_o(ic_busy_o), .dc_busy_o(dc_busy_o), .err_o(err_o)
    );

    typedef struct {
        logic       rst, icr, dcr, ack, rv;
        logic [1:0] tid;
        logic       mreq;
        int         src;  // 0: don't care, 1: I$ payload, 2: D$ payload
        logic       iack, dack, irv, drv, ib, db, err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, icr, dcr, ack, rv, input logic [1:0] tid,
                       input logic mreq, input int src,
                       input logic iack, dack, irv, drv, ib, db, err);
        vec_t v;
        v.rst = rst; v.icr = icr; v.dcr = dcr; v.ack = ack; v.rv = rv; v.tid = tid;
        v.mreq = mreq; v.src = src; v.iack = iack; v.dack = dack;
        v.irv = irv; v.drv = drv; v.ib = ib; v.db = db; v.err = err;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, icr, dcr, ack, rv, input logic [1:0] tid);
        rst_i = rst; ic_req_i = icr; dc_req_i = dcr; mem_ack_i = ack;
        mem_rtrn_vld_i = rv; mem_rtrn_tid_i = tid;
        mem_rtrn_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        ic_data_i = {4{32'hA5A5_0001}};
        dc_data_i = {4{32'h5A5A_0002}};
        drive(1, 0, 0, 0, 0, 0);

        //  rst icr dcr ack rv tid | mreq src iack dack irv drv ib db err
        add(1,0,0,0,0,0, 0,0,0,0,0,0,0,0,0);   // reset
        add(0,1,0,1,0,0, 1,1,1,0,0,0,0,0,0);   // single I$ request, zero-latency ack
        add(0,0,0,1,1,0, 0,0,0,0,1,0,1,0,0);   // tid 0 return to I$
        add(0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0);
        add(1,0,0,0,0,0, 0,0,0,0,0,0,0,0,0);   // pointer back to I$
        add(0,1,1,1,0,0, 1,1,1,0,0,0,0,0,0);   // round robin I,D,I,D
        add(0,1,1,1,0,0, 1,2,0,1,0,0,1,0,0);
        add(0,1,1,1,0,0, 1,1,1,0,0,0,1,1,0);
        add(0,1,1,1,0,0, 1,2,0,1,0,0,1,1,0);
        add(0,0,1,1,1,1, 1,2,0,1,0,1,1,1,0);   // ack + return to D$ with cnt_dc=2
        add(0,0,0,0,1,1, 0,0,0,0,0,1,1,1,0);
        add(0,0,0,0,1,1, 0,0,0,0,0,1,1,1,0);
        add(0,0,0,0,1,0, 0,0,0,0,1,0,1,0,0);
        add(0,0,0,0,1,0, 0,0,0,0,1,0,1,0,0);
        add(0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0);
        add(0,0,1,0,0,0, 1,2,0,0,0,0,0,0,0);   // owner lock on D$
        add(0,1,1,0,0,0, 1,2,0,0,0,0,0,0,0);
        add(0,1,1,0,0,0, 1,2,0,0,0,0,0,0,0);
        add(0,1,1,1,0,0, 1,2,0,1,0,0,0,0,0);
        add(0,1,1,1,0,0, 1,1,1,0,0,0,0,1,0);
        add(0,0,0,0,1,1, 0,0,0,0,0,1,1,1,0);
        add(0,0,0,0,1,0, 0,0,0,0,1,0,1,0,0);
        add(0,0,1,1,0,0, 1,2,0,1,0,0,0,0,0);   // four D$ acks, no returns
        add(0,0,1,1,0,0, 1,2,0,1,0,0,0,1,0);
        add(0,0,1,1,0,0, 1,2,0,1,0,0,0,1,0);
        add(0,0,1,1,0,0, 1,2,0,1,0,0,0,1,0);
        add(0,1,1,1,0,0, 1,1,1,0,0,0,0,1,0);   // D$ at limit, I$ served
        add(0,0,1,1,0,0, 0,0,0,0,0,0,1,1,0);
        add(0,0,1,1,1,1, 0,0,0,0,0,1,1,1,0);   // return frees a slot
        add(0,0,1,1,0,0, 1,2,0,1,0,0,1,1,0);
        add(1,0,1,0,0,0, 0,0,0,0,0,0,0,0,0);   // outputs quiet during reset
        add(0,0,0,0,1,1, 0,0,0,0,0,1,0,0,0);   // return with cnt_dc=0
        add(0,0,0,0,0,0, 0,0,0,0,0,0,0,0,1);
        add(0,0,0,0,0,0, 0,0,0,0,0,0,0,0,1);
        add(1,0,0,0,0,0, 0,0,0,0,0,0,0,0,1);
        add(0,1,0,0,0,0, 1,1,0,0,0,0,0,0,0);   // LOCK_IC
        add(0,1,0,0,0,0, 1,1,0,0,0,0,0,0,0);
        add(1,1,0,0,0,0, 0,0,0,0,0,0,0,0,0);   // reset mid-lock
        add(0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0);
        add(0,0,1,1,0,0, 1,2,0,1,0,0,0,0,0);   // lock was dropped
        add(0,1,0,0,0,0, 1,1,0,0,0,0,0,1,0);
        add(0,0,1,0,0,0, 1,1,0,0,0,0,0,1,0);   // I$ drops req while locked
        add(0,0,1,1,0,0, 1,1,1,0,0,0,0,1,1);
        add(0,0,1,1,0,0, 1,2,0,1,0,0,1,1,1);

        @(posedge clk_i); #1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].icr, vecs[i].dcr, vecs[i].ack, vecs[i].rv, vecs[i].tid);
            @(negedge clk_i);
            chk("mem_req", i, TW'(mem_req_o), TW'(vecs[i].mreq));
            chk("ic_ack", i, TW'(ic_ack_o), TW'(vecs[i].iack));
            chk("dc_ack", i, TW'(dc_ack_o), TW'(vecs[i].dack));
            chk("ic_rtrn_vld", i, TW'(ic_rtrn_vld_o), TW'(vecs[i].irv));
            chk("dc_rtrn_vld", i, TW'(dc_rtrn_vld_o), TW'(vecs[i].drv));
            chk("ic_busy", i, TW'(ic_busy_o), TW'(vecs[i].ib));
            chk("dc_busy", i, TW'(dc_busy_o), TW'(vecs[i].db));
            chk("err", i, TW'(err_o), TW'(vecs[i].err));
            if (vecs[i].src == 1) chk("mem_data_ic", i, TW'(mem_data_o), TW'(ic_data_i));
            if (vecs[i].src == 2) chk("mem_data_dc", i, TW'(mem_data_o), TW'(dc_data_i));
            if (vecs[i].rv && !vecs[i].rst) chk("rtrn_payload", i, rtrn_o, mem_rtrn_i);
            @(posedge clk_i); #1;
        end

        // Non-zero TIDs other than IcacheTid route to D$ and drain cnt_dc (2 -> 0).
        for (int t = 2; t < 4; t++) begin
            drive(0, 0, 0, 0, 1, 2'(t));
            @(negedge clk_i);
            chk("tid_route_dc", 100 + t, TW'({ic_rtrn_vld_o, dc_rtrn_vld_o}), TW'(2'b01));
            chk("tid_payload", 100 + t, rtrn_o, mem_rtrn_i);
            @(posedge clk_i); #1;
        end
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        chk("dc_drained", 104, TW'({dc_busy_o, ic_busy_o}), TW'(2'b01));
        chk("err_sticky", 104, TW'(err_o), TW'(1'b1));
        @(posedge clk_i); #1;
        drive(1, 0, 0, 0, 0, 0);
        @(posedge clk_i); #1;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        chk("err_cleared", 105, TW'(err_o), TW'(1'b0));
        chk("busy_cleared", 105, TW'({ic_busy_o, dc_busy_o}), TW'(2'b00));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
